// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for a D_FFEC register bank.
// Shares one write path among NREQ requesters and sequences a clear sweep.
module reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int NREG  = 8,
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic                  Clk,
    input  logic                  Clrn,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*AW-1:0]    Addr,
    input  logic [NREQ*WIDTH-1:0] Wdata,
    input  logic                  ClrAll,
    output logic [NREQ-1:0]       Gnt,
    output logic [NREG-1:0]       RegEn,
    output logic [WIDTH-1:0]      RegD,
    output logic                  Busy,
    output logic                  SweepDone,
    output logic                  Err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(NREG + 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  mask_q, mask_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREG-1:0]  regen_q, regen_d;
    logic [WIDTH-1:0] regd_q, regd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  elig;
    logic             found;
    logic [PW-1:0]    win;
    logic [AW-1:0]    win_addr;
    logic [WIDTH-1:0] win_data;
    int               j;

    assign elig = Req & ~mask_q;

    // Scan from ptr upward with wrap; the first eligible requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_q) + i) % NREQ;
            if (!found && elig[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
    end

    assign win_addr = Addr[int'(win)*AW +: AW];
    assign win_data = Wdata[int'(win)*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        regen_d = '0;
        regd_d  = regd_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ClrAll) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    mask_d  = '0;
                end else if (found) begin
                    gnt_d  = NREQ'(1) << win;
                    mask_d = NREQ'(1) << win;
                    regd_d = win_data;
                    if (int'(win_addr) < NREG) begin
                        regen_d = NREG'(1) << win_addr;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (int'(win) == NREQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win + 1'b1;
                    end
                end else begin
                    mask_d = '0;
                end
            end
            SWEEP: begin
                if (int'(cnt_q) < NREG) begin
                    regen_d = NREG'(1) << cnt_q;
                    regd_d  = '0;
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            regen_q <= '0;
            regd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            regen_q <= regen_d;
            regd_q  <= regd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Gnt       = gnt_q;
    assign RegEn     = regen_q;
    assign RegD      = regd_q;
    assign Busy      = busy_q;
    assign SweepDone = done_q;
    assign Err       = err_q;

endmodule
